// File: rtl/lsu_ctrl_pkg.sv
// Shared core types: data access width and LSU sequencer states.
// Also small helpers for misalignment, byte enables and store replication.
package core_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } data_type_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP
  } lsu_state_t;

  function automatic logic misaligned(
    input data_type_t dt,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (dt)
      BYTE:      m = 1'b0;
      HALF_WORD: m = off[0];
      default:   m = |off;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(
    input data_type_t dt,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (dt)
      BYTE:      be = 4'b0001 << off;
      HALF_WORD: be = 4'b0011 << off;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_rep(
    input data_type_t  dt,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = wd;
    unique case (dt)
      BYTE:      r = {4{wd[7:0]}};
      HALF_WORD: r = {2{wd[15:0]}};
      default:   r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Load data aligner: shifts the bus word by the byte offset and extends.
// Ports: rdata_i, off_i, dtype_i, sext_i in; data_o (32-bit result) out.
module lsu_load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  data_type_t  dtype_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = sh;
    unique case (dtype_i)
      BYTE: begin
        data_o = {{24{sext_i & sh[7]}}, sh[7:0]};
      end
      HALF_WORD: begin
        data_o = {{16{sext_i & sh[15]}}, sh[15:0]};
      end
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// LSU controller: sequences loads/stores onto an OBI-style data port.
// Ports: pipeline req/addr/wdata in, stall/rdata/exc/timeout out,
// dmem_* bus req/gnt/rvalid handshake. Optional RISCX_LSU_TIMEOUT_EN
// adds a response watchdog of TIMEOUT_CYCLES cycles.
module lsu_ctrl
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        mem_wen_i,
  input  data_type_t  data_type_i,
  input  logic        sign_extend_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        exc_valid_o,
  output logic        exc_store_o,
  output logic [31:0] exc_addr_o,
  output logic        timeout_o,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  data_type_t  type_q, type_d;
  logic        sext_q, sext_d;
  logic [31:0] ld_data;

`ifdef RISCX_LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      type_q  <= BYTE;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      type_q  <= type_d;
      sext_q  <= sext_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    off_d         = off_q;
    type_d        = type_q;
    sext_d        = sext_q;
    stall_o       = 1'b0;
    dmem_req_o    = 1'b0;
    rdata_valid_o = 1'b0;
    exc_valid_o   = 1'b0;
    exc_store_o   = 1'b0;
    exc_addr_o    = '0;
    timeout_o     = 1'b0;
`ifdef RISCX_LSU_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      LSU_IDLE: begin
        if (req_valid_i) begin
          if (misaligned(data_type_i, addr_i[1:0])) begin
            exc_valid_o = 1'b1;
            exc_store_o = mem_wen_i;
            exc_addr_o  = addr_i;
          end else begin
            addr_d  = {addr_i[31:2], 2'b00};
            we_d    = mem_wen_i;
            be_d    = byte_en(data_type_i, addr_i[1:0]);
            wdata_d = wdata_rep(data_type_i, wdata_i);
            off_d   = addr_i[1:0];
            type_d  = data_type_i;
            sext_d  = sign_extend_i;
            stall_o = 1'b1;
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i) begin
          state_d = LSU_RESP;
`ifdef RISCX_LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      LSU_RESP: begin
        if (dmem_rvalid_i) begin
          rdata_valid_o = ~we_q;
          state_d       = LSU_IDLE;
        end
`ifdef RISCX_LSU_TIMEOUT_EN
        // The cycle that would bring the count to the limit fires.
        else if (cnt_q == CNT_LAST) begin
          timeout_o = 1'b1;
          state_d   = LSU_IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
`else
        else begin
          stall_o = 1'b1;
        end
`endif
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  lsu_load_align u_align (
    .rdata_i (dmem_rdata_i),
    .off_i   (off_q),
    .dtype_i (type_q),
    .sext_i  (sext_q),
    .data_o  (ld_data)
  );

  assign rdata_o      = rdata_valid_o ? ld_data : '0;
  assign dmem_addr_o  = addr_q;
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed accesses, scoreboard of expected responses.
// Timeout case is exercised when RISCX_LSU_TIMEOUT_EN is defined.
module tb_lsu_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        mem_wen;
  data_type_t  dtype;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        exc_valid_o;
  logic        exc_store_o;
  logic [31:0] exc_addr_o;
  logic        timeout_o;
  logic        dmem_req_o;
  logic        gnt;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        rvalid;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_valid_i   (req_valid),
    .mem_wen_i     (mem_wen),
    .data_type_i   (dtype),
    .sign_extend_i (sext),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .exc_valid_o   (exc_valid_o),
    .exc_store_o   (exc_store_o),
    .exc_addr_o    (exc_addr_o),
    .timeout_o     (timeout_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_gnt_i    (gnt),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_rvalid_i (rvalid),
    .dmem_rdata_i  (rdata)
  );

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic        st;
    logic [31:0] addr;
  } exp_t;

  localparam int K_LOAD = 0;
  localparam int K_EXC  = 1;
  localparam int K_TMO  = 2;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 &&
        (rdata_valid_o || exc_valid_o || timeout_o)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: rv=%b exc=%b tmo=%b expected none",
                 rdata_valid_o, exc_valid_o, timeout_o);
      end else begin
        e = sb.pop_front();
        if (e.kind == K_LOAD) begin
          chk("load_valid", 32'(rdata_valid_o), 32'd1);
          chk("load_data", rdata_o, e.data);
        end else if (e.kind == K_EXC) begin
          chk("exc_valid", 32'(exc_valid_o), 32'd1);
          chk("exc_store", 32'(exc_store_o), 32'(e.st));
          chk("exc_addr", exc_addr_o, e.addr);
          chk("exc_stall", 32'(stall_o), 32'd0);
        end else begin
          chk("tmo_valid", 32'(timeout_o), 32'd1);
          chk("tmo_no_rdata", 32'(rdata_valid_o), 32'd0);
          chk("tmo_stall", 32'(stall_o), 32'd0);
        end
      end
    end
  end

  task automatic access(input string nm,
                        input logic we,
                        input data_type_t t,
                        input logic sx,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int gd,
                        input int rd,
                        input logic [31:0] rdat,
                        input logic [3:0] xbe,
                        input logic [31:0] xwd,
                        input logic [31:0] xrd);
    int st_cnt;
    st_cnt = 0;
    if (!we) sb.push_back('{kind: K_LOAD, data: xrd,
                            st: 1'b0, addr: 32'h0});
    @(posedge clk); #1;
    req_valid = 1'b1;
    mem_wen   = we;
    dtype     = t;
    sext      = sx;
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    if (stall_o) st_cnt++;
    chk({nm, "_req_accept"}, 32'(dmem_req_o), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    addr      = 32'hFFFF_FFFF;
    wdata     = 32'h0;
    for (int i = 0; i <= gd; i++) begin
      if (i == gd) gnt = 1'b1;
      @(negedge clk);
      if (stall_o) st_cnt++;
      chk({nm, "_req"}, 32'(dmem_req_o), 32'd1);
      chk({nm, "_addr"}, dmem_addr_o, {a[31:2], 2'b00});
      if (i == 0) begin
        chk({nm, "_be"}, 32'(dmem_be_o), 32'(xbe));
        chk({nm, "_we"}, 32'(dmem_we_o), 32'(we));
        chk({nm, "_wdata"}, dmem_wdata_o, xwd);
      end
      @(posedge clk); #1;
    end
    gnt = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      if (i == rd) begin
        rvalid = 1'b1;
        rdata  = rdat;
      end
      @(negedge clk);
      if (stall_o) st_cnt++;
      if (i == rd) chk({nm, "_stall_last"}, 32'(stall_o), 32'd0);
      chk({nm, "_req_resp"}, 32'(dmem_req_o), 32'd0);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rdata  = 32'h0;
    chk({nm, "_stall_cycles"}, st_cnt, 2 + gd + rd);
  endtask

  task automatic misal(input string nm,
                       input logic we,
                       input data_type_t t,
                       input logic [31:0] a);
    sb.push_back('{kind: K_EXC, data: 32'h0, st: we, addr: a});
    @(posedge clk); #1;
    req_valid = 1'b1;
    mem_wen   = we;
    dtype     = t;
    addr      = a;
    @(negedge clk);
    chk({nm, "_req"}, 32'(dmem_req_o), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_req_after"}, 32'(dmem_req_o), 32'd0);
    chk({nm, "_stall_after"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    mem_wen   = 1'b0;
    dtype     = WORD;
    sext      = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    gnt       = 1'b0;
    rvalid    = 1'b0;
    rdata     = 32'h0;
    #12;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'h0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_rvalid", 32'(rdata_valid_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    access("ldw", 1'b0, WORD, 1'b0, 32'h1000_0008, 32'h5555_AAAA,
           0, 1, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 32'hDEAD_BEEF);
    access("ldb_s", 1'b0, BYTE, 1'b1, 32'h1000_0003, 32'h1122_3344,
           0, 0, 32'h8012_3456, 4'b1000, 32'h4444_4444, 32'hFFFF_FF80);
    access("ldb_u", 1'b0, BYTE, 1'b0, 32'h1000_0003, 32'h1122_3344,
           1, 2, 32'h8012_3456, 4'b1000, 32'h4444_4444, 32'h0000_0080);
    access("sth", 1'b1, HALF_WORD, 1'b0, 32'h1000_0002, 32'h1234_ABCD,
           2, 0, 32'hCAFE_F00D, 4'b1100, 32'hABCD_ABCD, 32'h0);
    access("ldh_s", 1'b0, HALF_WORD, 1'b1, 32'h2000_0006, 32'h0,
           0, 0, 32'h8001_7FFF, 4'b1100, 32'h0, 32'hFFFF_8001);
    access("stb", 1'b1, BYTE, 1'b0, 32'h2000_0005, 32'h0000_00A5,
           0, 1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    access("ldh_u", 1'b0, HALF_WORD, 1'b0, 32'h3000_0000, 32'h0,
           0, 0, 32'h1234_F00D, 4'b0011, 32'h0, 32'h0000_F00D);

    misal("mis_sw", 1'b1, WORD, 32'h0000_0101);
    misal("mis_lh", 1'b0, HALF_WORD, 32'h0000_2003);

    // Slow grant, then reset while waiting for the response.
    @(posedge clk); #1;
    req_valid = 1'b1;
    mem_wen   = 1'b0;
    dtype     = WORD;
    sext      = 1'b0;
    addr      = 32'h4000_0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    addr      = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req", 32'(dmem_req_o), 32'd1);
      chk("hold_addr", dmem_addr_o, 32'h4000_0010);
      @(posedge clk); #1;
    end
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    @(negedge clk);
    chk("resp_stall", 32'(stall_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_addr", dmem_addr_o, 32'h0);
    chk("mid_rst_be", 32'(dmem_be_o), 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'h1357_9BDF;
    @(negedge clk);
    chk("late_rvalid", 32'(rdata_valid_o), 32'd0);
    chk("late_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;

`ifdef RISCX_LSU_TIMEOUT_EN
    begin
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      sb.push_back('{kind: K_TMO, data: 32'h0, st: 1'b0, addr: 32'h0});
      @(posedge clk); #1;
      req_valid = 1'b1;
      mem_wen   = 1'b0;
      dtype     = WORD;
      addr      = 32'h5000_0000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      gnt       = 1'b1;
      @(posedge clk); #1;
      gnt = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        n++;
        if (timeout_o) seen = 1'b1;
        @(posedge clk); #1;
      end
      chk("tmo_seen", 32'(seen), 32'd1);
      chk("tmo_cycle", n, 4);
      @(negedge clk);
      chk("tmo_idle_stall", 32'(stall_o), 32'd0);
      chk("tmo_idle_req", 32'(dmem_req_o), 32'd0);
      access("after_tmo", 1'b0, WORD, 1'b0, 32'h5000_0004, 32'h0,
             0, 0, 32'h0BAD_F00D, 4'hF, 32'h0, 32'h0BAD_F00D);
    end
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
